// File: rtl/pwm_pkg.sv
// Shared limits and saturating helpers for the multi-channel PWM generator.
`timescale 1ns/1ps
package pwm_pkg;

  localparam int unsigned PERIOD_MIN = 2;
  localparam int unsigned STEP_MIN   = 1;

  // Operands are duty values (< 2**CNT_W) zero-extended, so the sum cannot wrap.
  function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                          input int unsigned lim);
    int unsigned s;
    s = a + b;
    return (s > lim) ? lim : s;
  endfunction

  function automatic int unsigned sat_sub(input int unsigned a, input int unsigned b);
    return (a > b) ? (a - b) : 32'd0;
  endfunction

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pwm_duty_tracker.sv
// Per-channel sample edge tracker: steps the shadow duty up/down on rising/falling samples.
`timescale 1ns/1ps
module pwm_duty_tracker
  import pwm_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned PERIOD    = 100,
  parameter int unsigned STEP      = 5,
  parameter int unsigned DUTY_INIT = 50
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] sample,
  output logic        [CNT_W-1:0]  shadow
);

  logic signed [DATA_W-1:0] prev;
  logic                     prev_valid;
  logic        [CNT_W-1:0]  shadow_nxt;

  always_comb begin
    shadow_nxt = shadow;
    if (prev_valid) begin
      if (sample > prev)
        shadow_nxt = CNT_W'(sat_add(32'(shadow), STEP, PERIOD));
      else if (sample < prev)
        shadow_nxt = CNT_W'(sat_sub(32'(shadow), STEP));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev       <= '0;
      prev_valid <= 1'b0;
      shadow     <= CNT_W'(DUTY_INIT);
    end else if (sample_valid) begin
      prev       <= sample;
      prev_valid <= 1'b1;
      shadow     <= shadow_nxt;
    end
  end

endmodule

// File: rtl/pwm_multi_ch.sv
// N-channel PWM generator with double-buffered duty updated from signed sensor samples.
// Define PWM_CENTER_ALIGN_EN for centre-aligned pulses; default build is edge-aligned.
`timescale 1ns/1ps
module pwm_multi_ch
  import pwm_pkg::*;
#(
  parameter int unsigned NUM_CH    = 3,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned PERIOD    = 100,
  parameter int unsigned STEP      = 5,
  parameter int unsigned DUTY_INIT = 50
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       sample_valid,
  input  logic [NUM_CH*DATA_W-1:0]   sample_data,
  output logic [NUM_CH-1:0]          pwm_out,
  output logic [NUM_CH*CNT_W-1:0]    duty_out,
  output logic                       period_start
);

  if (clog2(PERIOD + 1) > CNT_W) begin : g_err_cnt_w
    $error("pwm_multi_ch: CNT_W too narrow for PERIOD");
  end
  if (PERIOD < PERIOD_MIN) begin : g_err_period
    $error("pwm_multi_ch: PERIOD below minimum");
  end
  if (DUTY_INIT > PERIOD) begin : g_err_duty_init
    $error("pwm_multi_ch: DUTY_INIT exceeds PERIOD");
  end
  if (STEP < STEP_MIN || STEP > PERIOD) begin : g_err_step
    $error("pwm_multi_ch: STEP out of range");
  end

  logic [CNT_W-1:0]  cnt;
  logic              cnt_last;
  logic              load;
  logic [CNT_W-1:0]  shadow [NUM_CH];
  logic [CNT_W-1:0]  active [NUM_CH];
  logic [NUM_CH-1:0] hit;

  assign cnt_last = (cnt == CNT_W'(PERIOD - 1));
  // While idle the active duty follows the shadow so a re-enable starts with the latest value.
  assign load     = !enable || cnt_last;

  // ---- stage 0: shared period counter ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt <= '0;
    else if (!enable || cnt_last)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    pwm_duty_tracker #(
      .DATA_W    (DATA_W),
      .CNT_W     (CNT_W),
      .PERIOD    (PERIOD),
      .STEP      (STEP),
      .DUTY_INIT (DUTY_INIT)
    ) u_trk (
      .clk          (clk),
      .reset_n      (reset_n),
      .sample_valid (sample_valid),
      .sample       (sample_data[ch*DATA_W +: DATA_W]),
      .shadow       (shadow[ch])
    );

    // ---- stage 0: active duty buffer, loaded only at period boundaries ----
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
        active[ch] <= CNT_W'(DUTY_INIT);
      else if (load)
        active[ch] <= shadow[ch];
    end

`ifdef PWM_CENTER_ALIGN_EN
    logic [CNT_W-1:0] lo;
    logic [CNT_W:0]   lo_end;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
        lo <= CNT_W'((PERIOD - DUTY_INIT) >> 1);
      else if (load)
        lo <= CNT_W'((PERIOD - 32'(shadow[ch])) >> 1);
    end

    assign lo_end  = {1'b0, lo} + {1'b0, active[ch]};
    assign hit[ch] = (cnt >= lo) && ({1'b0, cnt} < lo_end);
`else
    assign hit[ch] = (cnt < active[ch]);
`endif

    assign duty_out[ch*CNT_W +: CNT_W] = active[ch];
  end

  // ---- stage 1: registered outputs ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_out      <= '0;
      period_start <= 1'b0;
    end else begin
      pwm_out      <= enable ? hit : '0;
      period_start <= enable && (cnt == '0);
    end
  end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Randomized and directed bench for pwm_multi_ch against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_pwm_multi_ch;

  localparam int NUM_CH    = 3;
  localparam int DATA_W    = 16;
  localparam int CNT_W     = 8;
  localparam int PERIOD    = 100;
  localparam int STEP      = 5;
  localparam int DUTY_INIT = 50;

  logic                     clk = 1'b0;
  logic                     reset_n = 1'b1;
  logic                     enable = 1'b0;
  logic                     sample_valid = 1'b0;
  logic [NUM_CH*DATA_W-1:0] sample_data;
  logic [NUM_CH-1:0]        pwm_out;
  logic [NUM_CH*CNT_W-1:0]  duty_out;
  logic                     period_start;

  logic signed [DATA_W-1:0] samp [NUM_CH];

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  int                m_cnt;
  int                m_sh   [NUM_CH];
  int                m_act  [NUM_CH];
  int                m_lo   [NUM_CH];
  int                m_prev [NUM_CH];
  bit                m_pv   [NUM_CH];
  logic [NUM_CH-1:0] m_pwm;
  logic              m_ps;

  pwm_multi_ch #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_W),
    .PERIOD(PERIOD), .STEP(STEP), .DUTY_INIT(DUTY_INIT)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .pwm_out      (pwm_out),
    .duty_out     (duty_out),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  always_comb begin
    sample_data = '0;
    for (int i = 0; i < NUM_CH; i++) sample_data[i*DATA_W +: DATA_W] = samp[i];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp_duty(input int v);
    if (v < 0) return 0;
    if (v > PERIOD) return PERIOD;
    return v;
  endfunction

  function automatic bit in_pulse(input int c, input int a, input int lo);
`ifdef PWM_CENTER_ALIGN_EN
    return (c >= lo) && (c < lo + a);
`else
    return (lo >= 0) && (c < a);
`endif
  endfunction

  function automatic logic [NUM_CH*CNT_W-1:0] exp_duty();
    logic [NUM_CH*CNT_W-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_CH; i++) v[i*CNT_W +: CNT_W] = CNT_W'(m_act[i]);
    return v;
  endfunction

  function automatic int duty(input int ch);
    return int'(duty_out[ch*CNT_W +: CNT_W]);
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    m_pwm = '0;
    m_ps  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_sh[i]   = DUTY_INIT;
      m_act[i]  = DUTY_INIT;
      m_lo[i]   = (PERIOD - DUTY_INIT) / 2;
      m_prev[i] = 0;
      m_pv[i]   = 1'b0;
    end
  endtask

  // One clock edge of the specified behaviour, using state from before the edge.
  task automatic model_tick();
    int s;
    for (int i = 0; i < NUM_CH; i++) m_pwm[i] = enable && in_pulse(m_cnt, m_act[i], m_lo[i]);
    m_ps = enable && (m_cnt == 0);
    if (!enable || m_cnt == PERIOD - 1)
      for (int i = 0; i < NUM_CH; i++) begin
        m_act[i] = m_sh[i];
        m_lo[i]  = (PERIOD - m_sh[i]) / 2;
      end
    if (sample_valid)
      for (int i = 0; i < NUM_CH; i++) begin
        s = int'(samp[i]);
        if (m_pv[i]) begin
          if (s > m_prev[i])      m_sh[i] = clamp_duty(m_sh[i] + STEP);
          else if (s < m_prev[i]) m_sh[i] = clamp_duty(m_sh[i] - STEP);
        end
        m_prev[i] = s;
        m_pv[i]   = 1'b1;
      end
    m_cnt = enable ? (m_cnt + 1) % PERIOD : 0;
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, "_pwm"},    64'(pwm_out),      64'(m_pwm));
    check({pfx, "_duty"},   64'(duty_out),     64'(exp_duty()));
    check({pfx, "_pstart"}, 64'(period_start), 64'(m_ps));
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_tick();
    #1;
    check_outputs("cyc");
    sample_valid = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse(input int ch, input int val);
    samp[ch]     = DATA_W'(val);
    sample_valid = 1'b1;
    tick();
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    sample_valid = 1'b0;
    #1;
    model_reset();
    check_outputs("rst");
    @(posedge clk);
    #1;
    check_outputs("rst_hold");
    reset_n = 1'b1;
  endtask

  task automatic count_window(input int ch, output int hi, output int ps);
    hi = 0;
    ps = 0;
    repeat (PERIOD) begin
      tick();
      hi += int'(pwm_out[ch]);
      ps += int'(period_start);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, ps, r;
    bit exp_b;
    for (int i = 0; i < NUM_CH; i++) samp[i] = '0;
    #2;
    do_reset();

    // free-running at the reset duty
    enable = 1'b1;
    run(5);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      count_window(ch, hi, ps);
      check($sformatf("t1_high_ch%0d", ch), 64'(hi), 64'(DUTY_INIT));
      check($sformatf("t1_pstart_ch%0d", ch), 64'(ps), 64'd1);
    end

    // ch0 rising samples: first one only captures
    pulse(0, 10);
    pulse(0, 20);
    check("t2_not_yet", 64'(duty(0)), 64'd50);
    run(PERIOD);
    check("t2_duty55", 64'(duty(0)), 64'd55);
    pulse(0, 30);
    run(PERIOD);
    check("t2_duty60", 64'(duty(0)), 64'd60);

    // ch1 saturation at both ends
    for (int k = 1; k <= 11; k++) pulse(1, -k);
    run(PERIOD);
    check("t3_duty0", 64'(duty(1)), 64'd0);
    count_window(1, hi, ps);
    check("t3_low_all", 64'(hi), 64'd0);
    for (int k = -10; k <= 10; k++) pulse(1, k);
    run(PERIOD);
    check("t3_duty100", 64'(duty(1)), 64'(PERIOD));
    count_window(1, hi, ps);
    check("t3_high_all", 64'(hi), 64'(PERIOD));

    // sample arriving on the boundary cycle
    for (int k = 0; k < PERIOD + 2 && m_cnt != PERIOD - 1; k++) tick();
    pulse(0, 40);
    check("t4_boundary_keep", 64'(duty(0)), 64'd60);
    run(PERIOD);
    check("t4_next_boundary", 64'(duty(0)), 64'd65);

    // disable mid-period, update while idle, re-enable
    run(37);
    enable = 1'b0;
    tick();
    check("t5_pwm_off", 64'(pwm_out), 64'd0);
    pulse(0, 50);
    check("t5_idle_pre", 64'(duty(0)), 64'd65);
    tick();
    check("t5_idle_load", 64'(duty(0)), 64'd70);
    enable = 1'b1;
    tick();
    check("t5_restart_pstart", 64'(period_start), 64'd1);

    // ch2 at duty 20: pulse position within the period
    for (int k = 1; k <= 6; k++) pulse(2, -k);
    run(PERIOD);
    check("t6_duty20", 64'(duty(2)), 64'd20);
    for (int k = 0; k < 2 * PERIOD && period_start !== 1'b1; k++) tick();
    check("t6_sync", 64'(period_start), 64'd1);
    for (int j = 0; j < PERIOD; j++) begin
`ifdef PWM_CENTER_ALIGN_EN
      exp_b = (j >= 40) && (j < 60);
`else
      exp_b = (j < 20);
`endif
      check($sformatf("t6_pos%0d", j), 64'(pwm_out[2]), 64'(exp_b));
      tick();
    end

    // randomized samples, enable toggles and a mid-run reset
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 1500) do_reset();
      if ($urandom_range(0, 63) == 0) enable = !enable;
      if ($urandom_range(0, 7) == 0) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if ($urandom_range(0, 15) == 0)
            r = ($urandom_range(0, 1) == 1) ? 32767 : -32768;
          else
            r = int'($urandom_range(0, 8)) - 4;
          samp[i] = DATA_W'(r);
        end
        sample_valid = 1'b1;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
